// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default frame width
// used by uart_tx, uart_rx and uart_tx_arbiter.
package uart_pkg;

  localparam int UART_D_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT
  } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first set req bit at or above rr_ptr, wrapping at N_REQ-1.
// Done as rotate-down by rr_ptr, lowest-bit priority encode, rotate back.
module uart_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] src;
  logic [IDX_W-1:0] off;
  logic             found;
  int               win;

  always_comb begin
    rot   = '0;
    src   = '0;
    off   = '0;
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      src    = IDX_W'((i + int'(rr_ptr)) % N_REQ);
      rot[i] = req[src];
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
    win     = (int'(off) + int'(rr_ptr)) % N_REQ;
    win_idx = IDX_W'(win);
    win_oh  = found ? (N_REQ'(1) << win) : '0;
    win_any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared uart_tx; every output is a flop.
// Optional UART_ARB_LOCK_EN lets a locked owner chain bytes without re-arbitrating.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int D_W   = UART_D_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*D_W-1:0] req_data,
  input  logic [N_REQ-1:0]     lock,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 tx_start,
  output logic [D_W-1:0]       tx_data,
  input  logic                 tx_done
);

  localparam int IDX_W = $clog2(N_REQ);

  uart_arb_state_t  state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [D_W-1:0]   tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

`ifndef UART_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    case (state_q)
      ARB_IDLE: begin
        // Strobes are decided here so they are registered in the START cycle.
        if (pick_any) begin
          state_d    = ARB_START;
          grant_d    = pick_oh;
          gidx_d     = pick_idx;
          tx_data_d  = req_data[int'(pick_idx)*D_W +: D_W];
          tx_start_d = 1'b1;
          ack_d      = pick_oh;
          busy_d     = 1'b1;
        end
      end
      ARB_START: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (tx_done) begin
`ifdef UART_ARB_LOCK_EN
          if (lock[gidx_q] && req[gidx_q]) begin
            state_d    = ARB_START;
            tx_data_d  = req_data[int'(gidx_q)*D_W +: D_W];
            tx_start_d = 1'b1;
            ack_d      = grant_q;
          end else
`endif
          begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            busy_d   = 1'b0;
            rr_ptr_d = (gidx_q == IDX_W'(N_REQ-1)) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

endmodule
